// File: rtl/jt51_acc_seq.sv
// JT51 accumulator slot sequencer: 32-slot frame, group strobes, per-channel config and sample FIFO.
// Optional JT51_ACC_SEQ_OVF_EN adds the saturating dropped-sample counter ovf_cnt.
module jt51_acc_seq #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               run,
  input  logic               cfg_wr,
  input  logic [2:0]         cfg_ch,
  input  logic [1:0]         cfg_rl,
  input  logic [2:0]         cfg_con,
  input  logic signed [15:0] xleft,
  input  logic signed [15:0] xright,
  output logic [4:0]         slot,
  output logic               m1_enters,
  output logic               m2_enters,
  output logic               c1_enters,
  output logic               c2_enters,
  output logic               op31_acc,
  output logic [1:0]         rl_I,
  output logic [2:0]         con_I,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_left,
  output logic signed [15:0] out_right
`ifdef JT51_ACC_SEQ_OVF_EN
  ,
  output logic [7:0]         ovf_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0] state, state_nxt;
  logic [4:0] slot_nxt;
  logic       active_nxt;
  logic       skip;
  logic       push, pop, full, accept;

  logic [1:0] rl_mem  [8];
  logic [2:0] con_mem [8];

  logic signed [15:0] fl_mem [FIFO_DEPTH];
  logic signed [15:0] fr_mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = DRAIN;
      DRAIN: begin
        if (run)                 state_nxt = RUN;
        else if (slot == 5'd31)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // DRAIN leaves at slot 31, so the wrap of slot+1 already yields 0 there
    slot_nxt   = (state == IDLE) ? 5'd0 : slot + 5'd1;
    active_nxt = (state_nxt != IDLE);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      m1_enters <= 1'b0;
      m2_enters <= 1'b0;
      c1_enters <= 1'b0;
      c2_enters <= 1'b0;
      op31_acc  <= 1'b0;
      rl_I      <= 2'b11;
      con_I     <= '0;
      skip      <= 1'b1;
    end else if (cen) begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      m1_enters <= active_nxt && (slot_nxt[4:3] == 2'd0);
      m2_enters <= active_nxt && (slot_nxt[4:3] == 2'd1);
      c1_enters <= active_nxt && (slot_nxt[4:3] == 2'd2);
      c2_enters <= active_nxt && (slot_nxt[4:3] == 2'd3);
      op31_acc  <= active_nxt && (slot_nxt == 5'd31);
      if (cfg_wr && (cfg_ch == slot_nxt[2:0])) begin
        rl_I  <= cfg_rl;
        con_I <= cfg_con;
      end else begin
        rl_I  <= rl_mem[slot_nxt[2:0]];
        con_I <= con_mem[slot_nxt[2:0]];
      end
      if (state == IDLE)       skip <= 1'b1;
      else if (slot == 5'd17)  skip <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        rl_mem[i]  <= 2'b11;
        con_mem[i] <= '0;
      end
    end else if (cfg_wr) begin
      rl_mem[cfg_ch]  <= cfg_rl;
      con_mem[cfg_ch] <= cfg_con;
    end
  end

  assign push      = cen && (state != IDLE) && (slot == 5'd17) && !skip;
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid && out_ready;
  assign full      = ((wr_ptr - rd_ptr) == DEPTH_V);
  assign accept    = push && (!full || pop);
  assign out_left  = fl_mem[rd_ptr[AW-1:0]];
  assign out_right = fr_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fl_mem[i] <= '0;
        fr_mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        fl_mem[wr_ptr[AW-1:0]] <= xleft;
        fr_mem[wr_ptr[AW-1:0]] <= xright;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef JT51_ACC_SEQ_OVF_EN
  logic drop;
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst)                          ovf_cnt <= '0;
    else if (drop && ovf_cnt != '1)   ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_jt51_acc_seq.sv
// Directed self-checking bench for jt51_acc_seq: frame sequencing, config bypass, capture/skip, FIFO, drain, reset.
module tb_jt51_acc_seq;

  logic               clk = 1'b0;
  logic               rst, cen, run, cfg_wr, out_ready;
  logic [2:0]         cfg_ch, cfg_con;
  logic [1:0]         cfg_rl;
  logic signed [15:0] xleft, xright;
  logic [4:0]         slot;
  logic               m1_enters, m2_enters, c1_enters, c2_enters, op31_acc;
  logic [1:0]         rl_I;
  logic [2:0]         con_I;
  logic               busy, out_valid;
  logic signed [15:0] out_left, out_right;
`ifdef JT51_ACC_SEQ_OVF_EN
  logic [7:0]         ovf_cnt;
`endif

  int errors = 0;
  int checks = 0;

  jt51_acc_seq #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .cen(cen), .run(run),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_rl(cfg_rl), .cfg_con(cfg_con),
    .xleft(xleft), .xright(xright),
    .slot(slot), .m1_enters(m1_enters), .m2_enters(m2_enters),
    .c1_enters(c1_enters), .c2_enters(c2_enters), .op31_acc(op31_acc),
    .rl_I(rl_I), .con_I(con_I), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_left(out_left), .out_right(out_right)
`ifdef JT51_ACC_SEQ_OVF_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int s, f;
    rst = 1'b1; cen = 1'b1; run = 1'b0; cfg_wr = 1'b0;
    cfg_ch = 3'd3; cfg_rl = 2'b01; cfg_con = 3'd5;
    out_ready = 1'b0; xleft = 16'h1234; xright = 16'hEDCC;
    repeat (2) @(negedge clk);
    chk("rst_slot", slot, 0);
    chk("rst_m1", m1_enters, 0);
    chk("rst_c2", c2_enters, 0);
    chk("rst_op31", op31_acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rl", rl_I, 2'b11);
    chk("rst_con", con_I, 0);
`ifdef JT51_ACC_SEQ_OVF_EN
    chk("rst_ovf", ovf_cnt, 0);
`endif

    // Frames 0-2 free running, frames 3-4 exercise drain and re-raise
    rst = 1'b0; run = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 160; n++) begin
      s = n % 32; f = n / 32;
      @(negedge clk);
      chk("slot", slot, s);
      chk("m1", m1_enters, s < 8);
      chk("m2", m2_enters, s >= 8 && s < 16);
      chk("c1", c1_enters, s >= 16 && s < 24);
      chk("c2", c2_enters, s >= 24);
      chk("op31", op31_acc, s == 31);
      chk("busy", busy, 1);
      chk("rl", rl_I, ((s % 8) == 3 && n >= 3) ? 2'b01 : 2'b11);
      chk("con", con_I, ((s % 8) == 3 && n >= 3) ? 3'd5 : 3'd0);
      chk("valid", out_valid, (f >= 1 && s == 18));
      if (f >= 1 && s == 18) begin
        chk("left", {16'h0, out_left}, 32'h1234);
        chk("right", {16'h0, out_right}, 32'hEDCC);
      end
      cfg_wr = (n == 2);
      if (f == 3 && s == 9)  run = 1'b0;
      if (f == 3 && s == 20) run = 1'b1;
      if (f == 4 && s == 9)  run = 1'b0;
    end
    cfg_wr = 1'b0;
    @(negedge clk);
    chk("idle_slot", slot, 0);
    chk("idle_m1", m1_enters, 0);
    chk("idle_op31", op31_acc, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    @(negedge clk);
    chk("idle_hold_slot", slot, 0);
    chk("idle_hold_m1", m1_enters, 0);

    // Four frames with the sink stalled: skip, push, push, drop
    run = 1'b1; out_ready = 1'b0;
    for (int n = 0; n < 128; n++) begin
      s = n % 32; f = n / 32;
      @(negedge clk);
      chk("st_slot", slot, s);
      chk("st_busy", busy, 1);
      chk("st_valid", out_valid, n >= 50);
      xleft = 16'h1000 + 16'(f);
    end
    chk("st_head_l", {16'h0, out_left}, 32'h1001);
    chk("st_head_r", {16'h0, out_right}, 32'hEDCC);
`ifdef JT51_ACC_SEQ_OVF_EN
    chk("st_ovf", ovf_cnt, 1);
`endif

    cen = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("frz_slot", slot, 31);
    chk("frz_op31", op31_acc, 1);
    chk("frz_valid", out_valid, 1);
    chk("frz_pop_head", {16'h0, out_left}, 32'h1002);
    @(negedge clk);
    chk("frz_slot2", slot, 31);
    chk("frz_head2", {16'h0, out_left}, 32'h1002);

    cen = 1'b1;
    repeat (21) @(negedge clk);
    chk("pre_rst_slot", slot, 20);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    chk("mid_rst_slot", slot, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rl", rl_I, 2'b11);
    chk("mid_rst_con", con_I, 0);
    chk("mid_rst_c1", c1_enters, 0);
`ifdef JT51_ACC_SEQ_OVF_EN
    chk("mid_rst_ovf", ovf_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
